// File: rtl/flappy_pkg.sv
// Shared types and default constants for the flappy_dot game-loop control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package flappy_pkg;

    localparam int RATE_W_DEF          = 29;
    localparam int START_RATE_DEF      = 833333;
    localparam int MIN_RATE_DEF        = 416666;
    localparam int RATE_STEP_DEF       = 20833;
    localparam int TICKS_PER_LEVEL_DEF = 600;
    localparam int LEVEL_W_DEF         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_ERASE,
        ST_MOVE,
        ST_DRAW
    } state_t;

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter; zero is a same-cycle strobe when enabled at count 0.
// Latency: load/reload take effect on the next edge.
// Backpressure: en low freezes the count and masks the strobe.
module tick_counter #(
    parameter int           W         = 29,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         CLOCK_50,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] reload_val,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    assign zero = en && (count == '0);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            count <= RESET_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (zero) begin
            count <= reload_val;
        end else if (en) begin
            count <= count - ONE;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Game-loop controller: one erase/move/draw frame per divider tick, with difficulty ramp.
// Latency: tick and reqs appear the edge after the divider hits zero; req drops the edge after done.
// Backpressure: a slow done stalls the frame; ticks landing mid-frame are dropped and flagged in overrun.
module frame_scheduler
    import flappy_pkg::*;
#(
    parameter int RATE_W          = RATE_W_DEF,
    parameter int START_RATE      = START_RATE_DEF,
    parameter int MIN_RATE        = MIN_RATE_DEF,
    parameter int RATE_STEP       = RATE_STEP_DEF,
    parameter int TICKS_PER_LEVEL = TICKS_PER_LEVEL_DEF,
    parameter int LEVEL_W         = LEVEL_W_DEF
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               start,
    input  logic               pause,
    input  logic               game_over,
    output logic               erase_req,
    input  logic               erase_done,
    output logic               move_req,
    input  logic               move_done,
    output logic               draw_req,
    input  logic               draw_done,
    output logic               tick,
    output logic [RATE_W-1:0]  cur_rate,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               overrun
);

    localparam int                  FCNT_W    = $clog2(TICKS_PER_LEVEL + 1);
    localparam logic [RATE_W-1:0]   RATE_ONE  = RATE_W'(1);
    localparam logic [RATE_W-1:0]   START_V   = RATE_W'(START_RATE);
    localparam logic [RATE_W-1:0]   MIN_V     = RATE_W'(MIN_RATE);
    localparam logic [RATE_W-1:0]   STEP_V    = RATE_W'(RATE_STEP);
    localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(TICKS_PER_LEVEL - 1);
    localparam logic [FCNT_W-1:0]   FCNT_ONE  = FCNT_W'(1);
    localparam logic [LEVEL_W-1:0]  LVL_ONE   = LEVEL_W'(1);

    state_t            state, state_nxt;
    logic              zero;
    logic              restart;
    logic              cnt_en;
    logic              frame_done;
    logic [FCNT_W-1:0] frame_cnt;
    logic [RATE_W-1:0] reload_val;
    logic [RATE_W:0]   rate_dec;
    logic [RATE_W-1:0] rate_nxt;

    assign restart    = start && !game_over;
    assign cnt_en     = (state != ST_IDLE) && !pause;
    assign frame_done = (state == ST_DRAW) && draw_done && !start && !game_over;
    assign reload_val = cur_rate - RATE_ONE;

    // Extra bit keeps the subtraction from wrapping below zero before the floor clamp.
    assign rate_dec = {1'b0, cur_rate} - {1'b0, STEP_V};
    assign rate_nxt = (rate_dec[RATE_W] || (rate_dec < {1'b0, MIN_V})) ? MIN_V
                                                                         : rate_dec[RATE_W-1:0];

    assign erase_req = (state == ST_ERASE);
    assign move_req  = (state == ST_MOVE);
    assign draw_req  = (state == ST_DRAW);
    assign busy      = erase_req || move_req || draw_req;

    tick_counter #(
        .W         (RATE_W),
        .RESET_VAL (START_V - RATE_ONE)
    ) u_tick_counter (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .load       (restart),
        .load_val   (START_V - RATE_ONE),
        .en         (cnt_en),
        .reload_val (reload_val),
        .zero       (zero)
    );

    always_comb begin
        state_nxt = state;
        if (game_over) begin
            state_nxt = ST_IDLE;
        end else if (start) begin
            state_nxt = ST_WAIT_TICK;
        end else begin
            case (state)
                ST_WAIT_TICK: if (zero)       state_nxt = ST_ERASE;
                ST_ERASE:     if (erase_done) state_nxt = ST_MOVE;
                ST_MOVE:      if (move_done)  state_nxt = ST_DRAW;
                ST_DRAW:      if (draw_done)  state_nxt = ST_WAIT_TICK;
                default:                      state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            tick      <= 1'b0;
            overrun   <= 1'b0;
            level     <= '0;
            cur_rate  <= START_V;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            tick  <= zero && !start && !game_over;
            if (restart) begin
                overrun   <= 1'b0;
                level     <= '0;
                cur_rate  <= START_V;
                frame_cnt <= '0;
            end else begin
                if (zero && busy && !game_over) begin
                    overrun <= 1'b1;
                end
                if (frame_done) begin
                    if (frame_cnt == FCNT_LAST) begin
                        frame_cnt <= '0;
                        cur_rate  <= rate_nxt;
                        if (level != '1) begin
                            level <= level + LVL_ONE;
                        end
                    end else begin
                        frame_cnt <= frame_cnt + FCNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with a small frame period so ramps and overruns are reachable.
module tb_frame_scheduler;

    localparam int RW = 29;
    localparam int LW = 4;

    logic          CLOCK_50   = 1'b0;
    logic          resetn     = 1'b1;
    logic          start      = 1'b0;
    logic          pause      = 1'b0;
    logic          game_over  = 1'b0;
    logic          erase_done = 1'b0;
    logic          move_done  = 1'b0;
    logic          draw_done  = 1'b0;
    logic          erase_req, move_req, draw_req, tick, busy, overrun;
    logic [RW-1:0] cur_rate;
    logic [LW-1:0] level;

    int n_tests   = 0;
    int n_fail    = 0;
    int tick_seen = 0;
    bit hold_erase = 1'b0;

    typedef struct packed {
        logic          tick;
        logic          erase_req;
        logic          move_req;
        logic          draw_req;
        logic          busy;
        logic          overrun;
        logic [LW-1:0] level;
        logic [RW-1:0] cur_rate;
    } obs_t;

    typedef struct {
        int   ncyc;
        bit   start;
        obs_t exp;
    } vec_t;

    obs_t obs;
    assign obs = {tick, erase_req, move_req, draw_req, busy, overrun, level, cur_rate};

    frame_scheduler #(
        .RATE_W          (RW),
        .START_RATE      (10),
        .MIN_RATE        (4),
        .RATE_STEP       (3),
        .TICKS_PER_LEVEL (2),
        .LEVEL_W         (LW)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .pause      (pause),
        .game_over  (game_over),
        .erase_req  (erase_req),
        .erase_done (erase_done),
        .move_req   (move_req),
        .move_done  (move_done),
        .draw_req   (draw_req),
        .draw_done  (draw_done),
        .tick       (tick),
        .cur_rate   (cur_rate),
        .level      (level),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Datapath stand-in: answers each req one cycle after it rises.
    always @(posedge CLOCK_50) begin
        #2;
        erase_done = erase_req && !hold_erase;
        move_done  = move_req;
        draw_done  = draw_req;
    end

    always @(negedge CLOCK_50) if (tick) tick_seen++;

    function automatic obs_t mk(bit t, bit e, bit m, bit d, bit b, bit o, int lvl, int rate);
        obs_t r;
        r.tick      = t;
        r.erase_req = e;
        r.move_req  = m;
        r.draw_req  = d;
        r.busy      = b;
        r.overrun   = o;
        r.level     = LW'(lvl);
        r.cur_rate  = RW'(rate);
        return r;
    endfunction

    function automatic vec_t mv(int n, bit s, obs_t x);
        vec_t v;
        v.ncyc  = n;
        v.start = s;
        v.exp   = x;
        return v;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("tick=%b e=%b m=%b d=%b busy=%b ovr=%b lvl=%0d rate=%0d",
                         o.tick, o.erase_req, o.move_req, o.draw_req, o.busy, o.overrun,
                         o.level, o.cur_rate);
    endfunction

    task automatic check_obs(string nm, obs_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(obs), fmt(exp));
        end
    endtask

    task automatic check_int(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    vec_t vecs[$];
    int   ts;

    initial begin
        // Edge numbers in comments count from the edge that samples start (E0).
        vecs.push_back(mv(1, 1, mk(0,0,0,0,0,0, 0,10)));  // E0  waiting
        vecs.push_back(mv(9, 0, mk(0,0,0,0,0,0, 0,10)));  // E9  count at 0
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 0,10)));  // E10 tick, erase
        vecs.push_back(mv(1, 0, mk(0,0,1,0,1,0, 0,10)));  // E11 move
        vecs.push_back(mv(1, 0, mk(0,0,0,1,1,0, 0,10)));  // E12 draw
        vecs.push_back(mv(1, 0, mk(0,0,0,0,0,0, 0,10)));  // E13 frame 1 done
        vecs.push_back(mv(6, 0, mk(0,0,0,0,0,0, 0,10)));  // E19
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 0,10)));  // E20 period 10
        vecs.push_back(mv(3, 0, mk(0,0,0,0,0,0, 1,7)));   // E23 level-up
        vecs.push_back(mv(6, 0, mk(0,0,0,0,0,0, 1,7)));   // E29 old period still running
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 1,7)));   // E30 reload with 7
        vecs.push_back(mv(6, 0, mk(0,0,0,0,0,0, 1,7)));   // E36
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 1,7)));   // E37 period 7
        vecs.push_back(mv(3, 0, mk(0,0,0,0,0,0, 2,4)));   // E40 level 2
        vecs.push_back(mv(3, 0, mk(0,0,0,0,0,0, 2,4)));   // E43
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 2,4)));   // E44 period 7
        vecs.push_back(mv(3, 0, mk(0,0,0,0,0,0, 2,4)));   // E47
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 2,4)));   // E48 period 4
        vecs.push_back(mv(3, 0, mk(0,0,0,0,0,0, 3,4)));   // E51 level 3, floor holds
        vecs.push_back(mv(1, 0, mk(1,1,0,0,1,0, 3,4)));   // E52 period 4
        vecs.push_back(mv(2, 0, mk(0,0,0,1,1,0, 3,4)));   // E54 draw

        #2 resetn = 1'b0;
        cyc(2);
        check_obs("reset_state", mk(0,0,0,0,0,0, 0,10));
        resetn = 1'b1;
        cyc(1);

        foreach (vecs[i]) begin
            start = vecs[i].start;
            cyc(1);
            start = 1'b0;
            if (vecs[i].ncyc > 1) cyc(vecs[i].ncyc - 1);
            check_obs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Asynchronous reset in the middle of DRAW, away from any edge.
        #3 resetn = 1'b0;
        #1 check_obs("async_reset_mid_draw", mk(0,0,0,0,0,0, 0,10));
        cyc(1);
        check_obs("reset_held", mk(0,0,0,0,0,0, 0,10));
        resetn = 1'b1;
        cyc(1);

        // Stalled erase: second tick lands inside the frame.
        hold_erase = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;          // R0
        cyc(10);
        check_obs("ovr_first_tick", mk(1,1,0,0,1,0, 0,10));
        cyc(10);
        check_obs("ovr_tick_in_erase", mk(1,1,0,0,1,1, 0,10));
        cyc(2);
        check_obs("ovr_sticky", mk(0,1,0,0,1,1, 0,10));
        hold_erase = 1'b0;
        cyc(3);
        check_obs("ovr_frame_done", mk(0,0,0,0,0,1, 0,10));
        ts = tick_seen;
        cyc(4);
        check_obs("ovr_no_repeat", mk(0,0,0,0,0,1, 0,10));
        check_int("ovr_no_extra_tick", tick_seen, ts);
        cyc(1);
        check_obs("ovr_next_tick", mk(1,1,0,0,1,1, 0,10));
        start = 1'b1; cyc(1); start = 1'b0;          // S0
        check_obs("start_clears_ovr", mk(0,0,0,0,0,0, 0,10));

        // Pause for 5 edges mid-period delays the tick by 5.
        cyc(3);
        pause = 1'b1;
        cyc(5);
        pause = 1'b0;
        check_obs("pause_frozen", mk(0,0,0,0,0,0, 0,10));
        cyc(2);
        check_obs("pause_no_tick_at_10", mk(0,0,0,0,0,0, 0,10));
        cyc(4);
        check_obs("pause_no_tick_at_14", mk(0,0,0,0,0,0, 0,10));
        cyc(1);
        check_obs("pause_tick_at_15", mk(1,1,0,0,1,0, 0,10));

        // game_over during MOVE, racing move_done.
        cyc(1);
        check_obs("go_in_move", mk(0,0,1,0,1,0, 0,10));
        game_over = 1'b1; cyc(1); game_over = 1'b0;
        check_obs("go_to_idle", mk(0,0,0,0,0,0, 0,10));
        ts = tick_seen;
        cyc(25);
        check_int("go_no_ticks", tick_seen, ts);
        check_obs("go_idle_held", mk(0,0,0,0,0,0, 0,10));

        // start and game_over together: game_over wins.
        start = 1'b1; game_over = 1'b1; cyc(1); start = 1'b0; game_over = 1'b0;
        check_obs("go_beats_start", mk(0,0,0,0,0,0, 0,10));
        ts = tick_seen;
        cyc(15);
        check_int("go_beats_start_no_ticks", tick_seen, ts);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
